inst_mem_loader: RTL and testbench

// - Writer-side counterpart of the instruction memory read port: streams a program image into inst_mem

---
 rtl/riscv_loader_pkg.sv | 16 +
 rtl/inst_mem_loader_byte_packer.sv | 40 ++++
 rtl/inst_mem_loader.sv | 139 +++++++++++++
 tb/tb_inst_mem_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package riscv_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 4;

endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; the word is presented
// combinationally in the same cycle its 4th byte is accepted.
module byte_packer
    import riscv_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam int CW = $clog2(BYTES_PER_WORD);

    logic [CW-1:0] cnt_r;
    logic [23:0]   sh_r;

    // Byte position counter and shift register for the three lower bytes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
            sh_r  <= 24'h000000;
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
            sh_r  <= 24'h000000;
        end else if (byte_en) begin
            cnt_r <= cnt_r + CW'(1);
            sh_r  <= {byte_in, sh_r[23:8]};
        end
    end

    // Completed word: current byte is the most significant one
    always_comb begin
        word_valid = byte_en && (cnt_r == CW'(BYTES_PER_WORD - 1));
        word       = {byte_in, sh_r};
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Streams a length-prefixed, checksummed program image into instruction memory
// and holds the core in reset until the image has been loaded and verified.
module inst_mem_loader
    import riscv_loader_pkg::*;
#(
    parameter int DW             = 32,
    parameter int MEM_SIZE_IN_KB = 1,
    parameter int NO_OF_REGS     = MEM_SIZE_IN_KB * 1024 / 4,
    parameter int CNTW           = $clog2(NO_OF_REGS) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_i,
    output logic          byte_ready_o,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_waddr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          core_rst_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    loader_state_e   state_r, state_s;
    logic            accept_s, start_load_s, len_bad_s, last_word_s;
    logic            busy_s, done_s, err_s, core_rst_s;
    logic [31:0]     word_s;
    logic            word_valid_s;
    logic [CNTW-1:0] len_r, idx_r;
    logic [31:0]     csum_r;

    assign accept_s = byte_valid_i && byte_ready_o;

    byte_packer u_packer (
        .clk        (clk_i),
        .rst        (rst_i),
        .clr        (start_load_s),
        .byte_en    (accept_s),
        .byte_in    (byte_i),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // State register plus registered status outputs derived from the next state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            byte_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            core_rst_o   <= 1'b1;
        end else begin
            state_r      <= state_s;
            byte_ready_o <= busy_s;
            busy_o       <= busy_s;
            done_o       <= done_s;
            err_o        <= err_s;
            core_rst_o   <= core_rst_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s      = state_r;
        start_load_s = 1'b0;
        len_bad_s    = (word_s == 32'h0000_0000) || (word_s > 32'(NO_OF_REGS));
        last_word_s  = ((idx_r + CNTW'(1)) == len_r);
        case (state_r)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    state_s      = LEN;
                    start_load_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            LEN: begin
                if (word_valid_s) begin
                    state_s = len_bad_s ? ERR : DATA;
                end else begin
                    state_s = LEN;
                end
            end
            DATA: begin
                if (word_valid_s && last_word_s) begin
                    state_s = CSUM;
                end else begin
                    state_s = DATA;
                end
            end
            CSUM: begin
                if (word_valid_s) begin
                    state_s = (word_s == csum_r) ? DONE : ERR;
                end else begin
                    state_s = CSUM;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Status decode of the next state
    always_comb begin
        busy_s     = (state_s == LEN) || (state_s == DATA) || (state_s == CSUM);
        done_s     = (state_s == DONE);
        err_s      = (state_s == ERR);
        core_rst_s = (state_s != DONE);
    end

    // Length capture, memory write port and checksum accumulation
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_r       <= {CNTW{1'b0}};
            idx_r       <= {CNTW{1'b0}};
            csum_r      <= 32'h0000_0000;
            mem_we_o    <= 1'b0;
            mem_waddr_o <= {DW{1'b0}};
            mem_wdata_o <= {DW{1'b0}};
        end else begin
            mem_we_o <= 1'b0;
            if (start_load_s) begin
                idx_r  <= {CNTW{1'b0}};
                csum_r <= 32'h0000_0000;
            end else if (word_valid_s && (state_r == LEN)) begin
                len_r <= word_s[CNTW-1:0];
            end else if (word_valid_s && (state_r == DATA)) begin
                mem_we_o    <= 1'b1;
                mem_waddr_o <= DW'({idx_r, 2'b00});
                mem_wdata_o <= DW'(word_s);
                csum_r      <= csum_r ^ word_s;
                idx_r       <= idx_r + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader.
module tb_inst_mem_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o, mem_we_o, core_rst_o, busy_o, done_o, err_o;
    logic [31:0] mem_waddr_o, mem_wdata_o;

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] img[$];

    always #5 clk_i = ~clk_i;

    inst_mem_loader dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_waddr_o  (mem_waddr_o),
        .mem_wdata_o  (mem_wdata_o),
        .core_rst_o   (core_rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    // Records every memory write pulse
    always @(negedge clk_i) begin
        if (mem_we_o === 1'b1) begin
            wr_addr.push_back(mem_waddr_o);
            wr_data.push_back(mem_wdata_o);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int waited = 0;
        if (stall) begin
            repeat ($urandom_range(2, 0)) begin
                @(negedge clk_i);
                byte_valid_i = 1'b0;
            end
        end
        @(negedge clk_i);
        byte_valid_i = 1'b1;
        byte_i       = b;
        while (byte_ready_o !== 1'b1 && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        if (waited >= 100) begin
            n_cmp++;
            n_mis++;
            $display("FAIL byte_timeout: ready stayed %b, required 1", byte_ready_o);
        end else begin
            @(posedge clk_i);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] t;
            t = w >> (8 * k);
            send_byte(t[7:0], stall);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        start_i      = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
    endtask

    task automatic load_image(input logic [31:0] csum, input bit stall);
        pulse_start();
        send_word(32'(img.size()), stall);
        foreach (img[i]) send_word(img[i], stall);
        send_word(csum, stall);
        settle();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b1; byte_valid_i = 1'b1; byte_i = 8'hAA;
        repeat (3) @(negedge clk_i);
        n_cmp++; if (byte_ready_o !== 1'b0) begin n_mis++; $display("FAIL rst_ready: got %b required 0", byte_ready_o); end
        n_cmp++; if (mem_we_o !== 1'b0) begin n_mis++; $display("FAIL rst_we: got %b required 0", mem_we_o); end
        n_cmp++; if (mem_waddr_o !== 32'h0) begin n_mis++; $display("FAIL rst_waddr: got %h required 0", mem_waddr_o); end
        n_cmp++; if (mem_wdata_o !== 32'h0) begin n_mis++; $display("FAIL rst_wdata: got %h required 0", mem_wdata_o); end
        n_cmp++; if (core_rst_o !== 1'b1) begin n_mis++; $display("FAIL rst_core_rst: got %b required 1", core_rst_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL rst_busy: got %b required 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_mis++; $display("FAIL rst_done: got %b required 0", done_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL rst_err: got %b required 0", err_o); end
        start_i = 1'b0; byte_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        n_cmp++; if (byte_ready_o !== 1'b0) begin n_mis++; $display("FAIL idle_ready: got %b required 0", byte_ready_o); end
    endtask

    task automatic test_normal(input bit stall, input string tag);
        logic [31:0] ea[2];
        logic [31:0] ed[2];
        ea[0] = 32'h0; ea[1] = 32'h4;
        ed[0] = 32'h0000_0013; ed[1] = 32'h0010_0093;
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        n_cmp++; if (busy_o !== 1'b1 || core_rst_o !== 1'b1) begin n_mis++; $display("FAIL %s_busy_at_start: got busy=%b core_rst=%b required 1/1", tag, busy_o, core_rst_o); end
        send_word(32'd2, stall);
        // a start pulse mid-load must be ignored
        pulse_start();
        send_word(ed[0], stall);
        send_word(ed[1], stall);
        send_word(32'h0010_0080, stall);
        settle();
        n_cmp++; if (wr_addr.size() !== 2) begin n_mis++; $display("FAIL %s_wr_count: got %0d required 2", tag, wr_addr.size()); end
        for (int i = 0; i < 2 && i < wr_addr.size(); i++) begin
            n_cmp++;
            if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i]) begin
                n_mis++;
                $display("FAIL %s_write%0d: got (%h,%h) required (%h,%h)", tag, i, wr_addr[i], wr_data[i], ea[i], ed[i]);
            end
        end
        n_cmp++; if (done_o !== 1'b1 || err_o !== 1'b0) begin n_mis++; $display("FAIL %s_status: got done=%b err=%b required 1/0", tag, done_o, err_o); end
        n_cmp++; if (core_rst_o !== 1'b0 || busy_o !== 1'b0) begin n_mis++; $display("FAIL %s_core_rel: got core_rst=%b busy=%b required 0/0", tag, core_rst_o, busy_o); end
    endtask

    task automatic test_bad_csum();
        wr_addr.delete(); wr_data.delete();
        img.delete(); img.push_back(32'h0000_0013); img.push_back(32'h0010_0093);
        pulse_start();
        n_cmp++; if (done_o !== 1'b0 || core_rst_o !== 1'b1) begin n_mis++; $display("FAIL restart_clear: got done=%b core_rst=%b required 0/1", done_o, core_rst_o); end
        send_word(32'd2, 1'b0);
        send_word(img[0], 1'b0);
        send_word(img[1], 1'b0);
        send_word(32'h0000_0000, 1'b0);
        settle();
        n_cmp++; if (wr_addr.size() !== 2) begin n_mis++; $display("FAIL badcs_wr_count: got %0d required 2", wr_addr.size()); end
        n_cmp++; if (err_o !== 1'b1 || done_o !== 1'b0) begin n_mis++; $display("FAIL badcs_status: got err=%b done=%b required 1/0", err_o, done_o); end
        n_cmp++; if (core_rst_o !== 1'b1) begin n_mis++; $display("FAIL badcs_core_rst: got %b required 1", core_rst_o); end
    endtask

    task automatic test_len_err(input logic [31:0] n, input string tag);
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_word(n, 1'b0);
        settle();
        n_cmp++; if (err_o !== 1'b1 || done_o !== 1'b0) begin n_mis++; $display("FAIL %s_status: got err=%b done=%b required 1/0", tag, err_o, done_o); end
        n_cmp++; if (wr_addr.size() !== 0) begin n_mis++; $display("FAIL %s_no_write: got %0d writes required 0", tag, wr_addr.size()); end
        n_cmp++; if (byte_ready_o !== 1'b0 || busy_o !== 1'b0) begin n_mis++; $display("FAIL %s_idle: got ready=%b busy=%b required 0/0", tag, byte_ready_o, busy_o); end
    endtask

    task automatic test_full_memory();
        // words 0..255: XOR of 0..255 is 0
        wr_addr.delete(); wr_data.delete();
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back(32'(i));
        load_image(32'h0000_0000, 1'b0);
        n_cmp++; if (wr_addr.size() !== 256) begin n_mis++; $display("FAIL full_wr_count: got %0d required 256", wr_addr.size()); end
        if (wr_addr.size() == 256) begin
            n_cmp++;
            if (wr_addr[255] !== 32'h0000_03FC || wr_data[255] !== 32'd255) begin
                n_mis++;
                $display("FAIL full_last_write: got (%h,%h) required (000003fc,000000ff)", wr_addr[255], wr_data[255]);
            end
        end
        n_cmp++; if (done_o !== 1'b1 || err_o !== 1'b0) begin n_mis++; $display("FAIL full_status: got done=%b err=%b required 1/0", done_o, err_o); end
    endtask

    task automatic test_midload_reset();
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        n_cmp++; if (busy_o !== 1'b0 || byte_ready_o !== 1'b0 || core_rst_o !== 1'b1) begin n_mis++; $display("FAIL mrst_outputs: got busy=%b ready=%b core_rst=%b required 0/0/1", busy_o, byte_ready_o, core_rst_o); end
        n_cmp++; if (mem_waddr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin n_mis++; $display("FAIL mrst_wport: got (%h,%h) required (0,0)", mem_waddr_o, mem_wdata_o); end
        n_cmp++; if (wr_addr.size() !== 1 || (wr_addr.size() == 1 && wr_data[0] !== 32'h1122_3344)) begin n_mis++; $display("FAIL mrst_partial: got %0d writes required 1 of 11223344", wr_addr.size()); end
        rst_i = 1'b0;
        wr_addr.delete(); wr_data.delete();
        img.delete(); img.push_back(32'hDEAD_BEEF);
        load_image(32'hDEAD_BEEF, 1'b0);
        n_cmp++; if (wr_addr.size() !== 1) begin n_mis++; $display("FAIL mrst_reload_count: got %0d required 1", wr_addr.size()); end
        else begin
            n_cmp++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL mrst_reload_write: got (%h,%h) required (0,deadbeef)", wr_addr[0], wr_data[0]); end
        end
        n_cmp++; if (done_o !== 1'b1 || err_o !== 1'b0 || core_rst_o !== 1'b0) begin n_mis++; $display("FAIL mrst_done: got done=%b err=%b core_rst=%b required 1/0/0", done_o, err_o, core_rst_o); end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00;
        test_reset();
        test_normal(1'b0, "normal");
        test_bad_csum();
        test_len_err(32'd0, "len_zero");
        test_len_err(32'd257, "len_big");
        test_normal(1'b1, "stall");
        test_full_memory();
        test_midload_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
